// File: rtl/instr_imm_encoder_if.sv
// Request/response bundle for the immediate encoder: request side, instruction
// output side, error reporting and the accept/reject counters.
interface instr_imm_encoder_if #(
    parameter int unsigned CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [63:0]      in_imm;
    logic [4:0]       in_rn;
    logic [4:0]       in_rt;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] reject_cnt;

    modport master (
        output in_valid, in_op, in_imm, in_rn, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, err_pulse, err_code, accept_cnt, reject_cnt
    );

    modport slave (
        input  in_valid, in_op, in_imm, in_rn, in_rt, out_ready,
        output in_ready, out_valid, out_instr, err_pulse, err_code, accept_cnt, reject_cnt
    );
endinterface

// File: rtl/instr_imm_encoder.sv
// Packs a signed 64-bit immediate plus register fields into a LEGv8 D-type or CBZ
// word through a two-stage valid/ready pipeline (S1 range check, S2 assembled word).
module instr_imm_encoder #(
    parameter int unsigned CNT_W = 32
) (
    input logic              clk,
    input logic              reset,
    instr_imm_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        OP_LDUR = 2'b00,
        OP_STUR = 2'b01,
        OP_CBZ  = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_OP    = 2'b10
    } err_e;

    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [63:0]      s1_imm_q, s1_imm_d;
    logic [4:0]       s1_rn_q, s1_rn_d;
    logic [4:0]       s1_rt_q, s1_rt_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic             err_pulse_q, err_pulse_d;
    err_e             err_code_q, err_code_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    logic        ok9, ok19;
    logic        s1_adv, in_rdy, in_fire, out_fire, s1_fire, drop;
    err_e        drop_code;
    logic [31:0] word;

    assign ok9  = (s1_imm_q[63:8]  == {56{s1_imm_q[8]}});
    assign ok19 = (s1_imm_q[63:18] == {46{s1_imm_q[18]}});

    always_comb begin
        word      = '0;
        drop_code = ERR_NONE;
        unique case (s1_op_q)
            OP_LDUR: begin
                word = {11'h7C2, s1_imm_q[8:0], 2'b00, s1_rn_q, s1_rt_q};
                if (!ok9) drop_code = ERR_RANGE;
            end
            OP_STUR: begin
                word = {11'h7C0, s1_imm_q[8:0], 2'b00, s1_rn_q, s1_rt_q};
                if (!ok9) drop_code = ERR_RANGE;
            end
            OP_CBZ: begin
                word = {8'hB4, s1_imm_q[18:0], s1_rt_q};
                if (!ok19) drop_code = ERR_RANGE;
            end
            OP_ILL: drop_code = ERR_OP;
        endcase
    end

    always_comb begin
        s1_adv   = !s2_valid_q || bus.out_ready;
        in_rdy   = !s1_valid_q || s1_adv;
        in_fire  = bus.in_valid && in_rdy;
        out_fire = s2_valid_q && bus.out_ready;
        s1_fire  = s1_valid_q && s1_adv;
        drop     = s1_fire && (drop_code != ERR_NONE);

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_imm_d   = s1_imm_q;
        s1_rn_d    = s1_rn_q;
        s1_rt_d    = s1_rt_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(bus.in_op);
            s1_imm_d   = bus.in_imm;
            s1_rn_d    = bus.in_rn;
            s1_rt_d    = bus.in_rt;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // A dropped entry leaves S1 without ever occupying S2
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        if (s1_fire && !drop) begin
            s2_valid_d = 1'b1;
            s2_instr_d = word;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end

        err_pulse_d = drop;
        err_code_d  = drop ? drop_code : err_code_q;

        acc_d = acc_q;
        if (out_fire && (acc_q != '1)) acc_d = acc_q + CNT_W'(1);
        rej_d = rej_q;
        if (drop && (rej_q != '1)) rej_d = rej_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_LDUR;
            s1_imm_q    <= '0;
            s1_rn_q     <= '0;
            s1_rt_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            acc_q       <= '0;
            rej_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_imm_q    <= s1_imm_d;
            s1_rn_q     <= s1_rn_d;
            s1_rt_q     <= s1_rt_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            acc_q       <= acc_d;
            rej_q       <= rej_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_instr  = s2_instr_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_code   = err_code_q;
    assign bus.accept_cnt = acc_q;
    assign bus.reject_cnt = rej_q;
endmodule
